me_sad_search: RTL and testbench
================================

// Module: me_sad_search
// PURPOSE
//  Parametrised full-search block-matching engine for the 4K60 motion-estimation datapath; successor to the fixed 8x8/16x16 SAD core.
//  Loads an N x N current block, then streams N+R-1 reference rows and accumulates SAD for all R x R candidate offsets.
//  Reports minimum SAD and signed motion vector. Adds start/busy control and valid/ready row handshakes.
// PARAMETERS
//  PW    8   pixel width, bits
//  N     8   block edge, pixels (>=2)
//  R     16  search positions per axis (power of 2, >=2); offsets -R/2..R/2-1
//  SADW  clog2(N*N*(2^PW-1)+1)  SAD width, derived (14 at defaults)
//  MVW   clog2(R)               motion-vector width, derived (4 at defaults)
// PORTS
//  clk               in   1             rising-edge clock
//  rst_n             in   1             asynchronous active-low reset
//  start             in   1             begin a new search; honoured only in IDLE
//  busy              out  1             high from accepted start until sad_en
//  cur_row           in   N*PW          current-block row; pixel k at [(N-k)*PW-1 -: PW]
//  cur_valid         in   1             cur_row valid
//  cur_ready         out  1             high only in LOAD_CUR
//  ref_row           in   (N+R-1)*PW    reference row, same MSB-first pixel order
//  ref_valid         in   1             ref_row valid
//  ref_ready         out  1             high only in SEARCH
//  sad_en            out  1             1-cycle pulse: results valid
//  sad_min           out  SADW          minimum SAD
//  motion_vec_x_min  out  MVW           signed dx = col_idx - R/2, two's complement
//  motion_vec_y_min  out  MVW           signed dy = row_idx - R/2, two's complement
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, accumulators and counters cleared. Reset mid-operation aborts and discards the search.
//  FSM: IDLE -start-> LOAD_CUR -(N cur handshakes)-> SEARCH -(N+R-1 ref handshakes)-> FLUSH -> DONE -> IDLE.
//  start in IDLE clears all R*R accumulators and row counters. start while busy is ignored.
//  Handshake: a transfer occurs when valid && ready on the same clk edge. Gaps and stalls are legal.
//   ready never depends combinationally on valid.
//  Search row j (0..N+R-2), for each row_idx in 0..R-1 with r=j-row_idx in 0..N-1:
//   acc[row_idx][c] += sum_k |cur[r][k] - ref_j[c+k]|, for c in 0..R-1, k in 0..N-1.
//  Row row_idx is complete after search row row_idx+N-1.
//   In the following cycle, its R SADs go through the min tree and are compared against the running minimum.
//  Tie-break: strict-less replaces the running minimum.
//   Within a row the lowest c wins; across rows the earlier row_idx wins (first minimum in raster order).
//  Arithmetic: |a-b| on PW+1-bit signed difference. Row sums N*PW->clog2 exact. SADW never overflows; no saturation.
//  Latency: sad_en pulses exactly 2 cycles after the last ref handshake. busy falls in the same cycle as sad_en.
//  sad_min and both MV outputs update only with sad_en and hold until the next sad_en or reset.
//  DONE -> IDLE: start may be asserted in the cycle after sad_en and is accepted.
// STRUCTURE
//  Shared package me_pkg:
//   - clog2 function
//   - FSM state localparams
//   - pixel-extract macro/function
//   - SADW/MVW derivation
//  Sub-module sad_row_unit (N absolute differences + adder tree, combinational, parametrised by PW and N).
//   Instantiated R*R times, one per (row_idx, c) lane; row select by r=j-row_idx mux.
//  Remaining logic lives in top:
//   - cur-block register file (N x N*PW)
//   - accumulator array
//   - row counter
//   - per-row min tree
//   - running-min register
// TESTING (defaults PW=8 N=8 R=16)
//  1. cur all 0; ref all 255 except an 8x8 zero patch at rows 3..10, pixels 5..12
//     -> sad_min=0, mv_x=-3 (4'hD), mv_y=-5 (4'hB).
//  2. cur all 0, ref all 255 -> sad_min=16320, mv (-8,-8) (4'h8,4'h8); checks SADW headroom and raster tie-break.
//  3. cur all 0, ref all 0 except one pixel=1 at row 0, pixel 0
//     -> sad_min=0, mv (-7,-8), i.e. the first zero-SAD candidate, c=1.
//  4. Repeat test 1 with random valid gaps on cur/ref and ready sampling
//     -> identical result; sad_en exactly 2 cycles after the 23rd ref handshake.
//  5. Assert rst_n low during SEARCH row 10 -> all outputs 0, busy 0, no sad_en.
//     A new start then gives correct test-1 result.
//  6. start pulsed while busy in LOAD_CUR and SEARCH -> ignored.
//     Exactly one sad_en; outputs hold old values until it fires.

Source files
------------

// File: rtl/me_sad_search_pkg.sv
// Shared FSM encoding and width/pixel helpers for the full-search SAD engine.
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CUR = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DONE     = 3'd4
    } me_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sad_width(input int pw, input int n);
        return clog2(n * n * ((1 << pw) - 1) + 1);
    endfunction

    function automatic int row_sum_width(input int pw, input int n);
        return clog2(n * ((1 << pw) - 1) + 1);
    endfunction

    // LSB position of pixel k in an MSB-first row of n pixels
    function automatic int pix_lsb(input int k, input int n, input int pw);
        return (n - 1 - k) * pw;
    endfunction

endpackage

// File: rtl/me_sad_search_sad_row_unit.sv
// One candidate lane: N absolute differences summed into an exact row SAD.
module sad_row_unit
    import me_pkg::*;
#(
    parameter int PW = 8,
    parameter int N  = 8
) (
    input  logic [N*PW-1:0]                  cur_pix,
    input  logic [N*PW-1:0]                  ref_pix,
    output logic [row_sum_width(PW, N)-1:0]  sad
);

    localparam int RSW = row_sum_width(PW, N);

    always_comb begin
        logic [PW:0]   d;
        logic [PW-1:0] a;
        sad = '0;
        for (int k = 0; k < N; k++) begin
            d   = {1'b0, cur_pix[pix_lsb(k, N, PW) +: PW]} - {1'b0, ref_pix[pix_lsb(k, N, PW) +: PW]};
            a   = d[PW] ? PW'(-d) : d[PW-1:0];
            sad = sad + RSW'(a);
        end
    end

endmodule

// File: rtl/me_sad_search.sv
// Full-search block matcher: loads an N x N block, streams N+R-1 reference rows,
// accumulates all R x R candidate SADs and reports the first minimum in raster order.
module me_sad_search
    import me_pkg::*;
#(
    parameter int PW   = 8,
    parameter int N    = 8,
    parameter int R    = 16,
    parameter int SADW = sad_width(PW, N),
    parameter int MVW  = clog2(R)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    input  logic [N*PW-1:0]       cur_row,
    input  logic                  cur_valid,
    output logic                  cur_ready,
    input  logic [(N+R-1)*PW-1:0] ref_row,
    input  logic                  ref_valid,
    output logic                  ref_ready,
    output logic                  sad_en,
    output logic [SADW-1:0]       sad_min,
    output logic [MVW-1:0]        motion_vec_x_min,
    output logic [MVW-1:0]        motion_vec_y_min
);

    localparam int RSW    = row_sum_width(PW, N);
    localparam int CW     = clog2(N);
    localparam int JW     = clog2(N + R - 1);
    localparam int LAST_J = N + R - 2;

    me_state_e state_q, state_d;

    logic [CW-1:0]                 cur_cnt_q, cur_cnt_d;
    logic [JW-1:0]                 ref_cnt_q, ref_cnt_d;
    logic [N-1:0][N*PW-1:0]        cur_q, cur_d;
    logic [R-1:0][R-1:0][SADW-1:0] acc_q, acc_d;
    logic [R-1:0][R-1:0][RSW-1:0]  lane_sad;
    logic [R-1:0][N*PW-1:0]        row_cur;
    logic [R-1:0]                  row_hit;

    logic            cmp_vld_q, cmp_vld_d;
    logic [MVW-1:0]  cmp_row_q, cmp_row_d;
    logic            best_vld_q, best_vld_d;
    logic [SADW-1:0] best_sad_q, best_sad_d;
    logic [MVW-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;
    logic            sad_en_q, sad_en_d;
    logic [SADW-1:0] sad_min_q, sad_min_d;
    logic [MVW-1:0]  mvx_q, mvx_d, mvy_q, mvy_d;

    logic [SADW-1:0] row_min;
    logic [MVW-1:0]  row_min_c;
    logic            start_ok, cur_fire, ref_fire;

    assign start_ok = start && (state_q == ST_IDLE);
    assign cur_fire = cur_valid && cur_ready;
    assign ref_fire = ref_valid && ref_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_LOAD_CUR;
            ST_LOAD_CUR: if (cur_fire && cur_cnt_q == CW'(N - 1)) state_d = ST_SEARCH;
            ST_SEARCH:   if (ref_fire && ref_cnt_q == JW'(LAST_J)) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        cur_ready = (state_q == ST_LOAD_CUR);
        ref_ready = (state_q == ST_SEARCH);
    end

    always_comb begin
        cur_cnt_d = cur_cnt_q;
        ref_cnt_d = ref_cnt_q;
        cur_d     = cur_q;
        if (start_ok) begin
            cur_cnt_d = '0;
            ref_cnt_d = '0;
        end
        if (cur_fire) begin
            for (int r = 0; r < N; r++) begin
                if (cur_cnt_q == CW'(r)) cur_d[r] = cur_row;
            end
            cur_cnt_d = cur_cnt_q + 1'b1;
        end
        if (ref_fire) ref_cnt_d = ref_cnt_q + 1'b1;
    end

    // Candidate row rr sees block row r = j - rr while that index is inside the block.
    always_comb begin
        row_cur = '0;
        row_hit = '0;
        for (int rr = 0; rr < R; rr++) begin
            for (int r = 0; r < N; r++) begin
                if (ref_cnt_q == JW'(rr + r)) begin
                    row_hit[rr] = 1'b1;
                    row_cur[rr] = cur_q[r];
                end
            end
        end
    end

    for (genvar gr = 0; gr < R; gr++) begin : g_row
        for (genvar gc = 0; gc < R; gc++) begin : g_col
            sad_row_unit #(.PW(PW), .N(N)) u_sad (
                .cur_pix (row_cur[gr]),
                .ref_pix (ref_row[pix_lsb(gc + N - 1, N + R - 1, PW) +: N*PW]),
                .sad     (lane_sad[gr][gc])
            );
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (start_ok) begin
            acc_d = '0;
        end else if (ref_fire) begin
            for (int rr = 0; rr < R; rr++) begin
                for (int cc = 0; cc < R; cc++) begin
                    if (row_hit[rr]) acc_d[rr][cc] = acc_q[rr][cc] + SADW'(lane_sad[rr][cc]);
                end
            end
        end
    end

    // Row j - (N-1) receives its last contribution on handshake j; compare it next cycle.
    always_comb begin
        cmp_vld_d = ref_fire && (ref_cnt_q >= JW'(N - 1));
        cmp_row_d = cmp_row_q;
        if (ref_fire) cmp_row_d = MVW'(ref_cnt_q - JW'(N - 1));
    end

    always_comb begin
        row_min   = acc_q[cmp_row_q][0];
        row_min_c = '0;
        for (int c = 1; c < R; c++) begin
            if (acc_q[cmp_row_q][c] < row_min) begin
                row_min   = acc_q[cmp_row_q][c];
                row_min_c = MVW'(c);
            end
        end
    end

    always_comb begin
        best_vld_d = best_vld_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        if (start_ok) begin
            best_vld_d = 1'b0;
        end else if (cmp_vld_q && (!best_vld_q || row_min < best_sad_q)) begin
            best_vld_d = 1'b1;
            best_sad_d = row_min;
            best_x_d   = row_min_c;
            best_y_d   = cmp_row_q;
        end
    end

    always_comb begin
        sad_en_d  = (state_q == ST_DONE);
        sad_min_d = sad_min_q;
        mvx_d     = mvx_q;
        mvy_d     = mvy_q;
        if (state_q == ST_DONE) begin
            sad_min_d = best_sad_q;
            mvx_d     = best_x_q - MVW'(R / 2);
            mvy_d     = best_y_q - MVW'(R / 2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cnt_q  <= '0;
            ref_cnt_q  <= '0;
            cur_q      <= '0;
            acc_q      <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_row_q  <= '0;
            best_vld_q <= 1'b0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            sad_en_q   <= 1'b0;
            sad_min_q  <= '0;
            mvx_q      <= '0;
            mvy_q      <= '0;
        end else begin
            cur_cnt_q  <= cur_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_row_q  <= cmp_row_d;
            best_vld_q <= best_vld_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            sad_en_q   <= sad_en_d;
            sad_min_q  <= sad_min_d;
            mvx_q      <= mvx_d;
            mvy_q      <= mvy_d;
        end
    end

    assign sad_en           = sad_en_q;
    assign sad_min          = sad_min_q;
    assign motion_vec_x_min = mvx_q;
    assign motion_vec_y_min = mvy_q;

endmodule

// File: tb/tb_me_sad_search.sv
// Directed + random checks of me_sad_search against a brute-force full-search model.
module tb_me_sad_search;

    localparam int PW = 8, N = 8, R = 16, W = N + R - 1, SADW = 14, MVW = 4;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic cur_valid = 1'b0, ref_valid = 1'b0;
    logic [N*PW-1:0] cur_row = '0;
    logic [W*PW-1:0] ref_row = '0;
    logic busy, cur_ready, ref_ready, sad_en;
    logic [SADW-1:0] sad_min;
    logic [MVW-1:0]  mvx, mvy;

    int cur_m [N][N];
    int ref_m [W][W];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, last_ref_cyc = 0, sad_en_cnt = 0;
    int exp_sad, exp_x, exp_y;

    always #5 clk = ~clk;

    me_sad_search #(.PW(PW), .N(N), .R(R)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy),
        .cur_row          (cur_row),
        .cur_valid        (cur_valid),
        .cur_ready        (cur_ready),
        .ref_row          (ref_row),
        .ref_valid        (ref_valid),
        .ref_ready        (ref_ready),
        .sad_en           (sad_en),
        .sad_min          (sad_min),
        .motion_vec_x_min (mvx),
        .motion_vec_y_min (mvy)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ref_valid && ref_ready) last_ref_cyc = cyc;
        if (sad_en) sad_en_cnt = sad_en_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // kind 1: zero patch, 2: all 255, 3: single 1 pixel, 4: random
    task automatic setup(input int kind);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                cur_m[r][k] = (kind == 4) ? int'($urandom_range(0, 255)) : 0;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++) begin
                case (kind)
                    1:       ref_m[y][x] = (y >= 3 && y <= 10 && x >= 5 && x <= 12) ? 0 : 255;
                    2:       ref_m[y][x] = 255;
                    3:       ref_m[y][x] = (y == 0 && x == 0) ? 1 : 0;
                    default: ref_m[y][x] = int'($urandom_range(0, 255));
                endcase
            end
    endtask

    // Exhaustive search over all offsets, first strict minimum in raster order.
    task automatic model();
        int best, s, d, bx, by;
        best = -1; bx = 0; by = 0;
        for (int y = 0; y < R; y++)
            for (int x = 0; x < R; x++) begin
                s = 0;
                for (int r = 0; r < N; r++)
                    for (int k = 0; k < N; k++) begin
                        d = cur_m[r][k] - ref_m[y + r][x + k];
                        s += (d < 0) ? -d : d;
                    end
                if (best < 0 || s < best) begin
                    best = s; bx = x; by = y;
                end
            end
        exp_sad = best;
        exp_x   = (bx - R / 2) & (R - 1);
        exp_y   = (by - R / 2) & (R - 1);
    endtask

    task automatic run(input bit gaps, input bit poke, input int abort_row, input int hold_sad);
        logic [N*PW-1:0] cv;
        logic [W*PW-1:0] rv;
        int guard;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy after start", {31'b0, busy}, 1);
        for (int r = 0; r < N; r++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin cur_valid = 1'b0; @(negedge clk); end
            for (int k = 0; k < N; k++) cv[(N-1-k)*PW +: PW] = cur_m[r][k][PW-1:0];
            cur_row = cv; cur_valid = 1'b1; start = poke && (r == 3);
            guard = 0;
            while (!cur_ready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) check("cur_ready timeout", 0, 1);
            @(negedge clk);
        end
        cur_valid = 1'b0; start = 1'b0;
        if (hold_sad >= 0) check("hold after load", {18'b0, sad_min}, hold_sad);
        for (int j = 0; j < W; j++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin ref_valid = 1'b0; @(negedge clk); end
            for (int x = 0; x < W; x++) rv[(W-1-x)*PW +: PW] = ref_m[j][x][PW-1:0];
            ref_row = rv; ref_valid = 1'b1; start = poke && (j == 5);
            if (j == abort_row) begin
                rst_n = 1'b0;
                #1;
                check("abort sad_en", {31'b0, sad_en}, 0);
                check("abort sad_min", {18'b0, sad_min}, 0);
                check("abort mvx", {28'b0, mvx}, 0);
                check("abort mvy", {28'b0, mvy}, 0);
                check("abort busy", {31'b0, busy}, 0);
                check("abort ref_ready", {31'b0, ref_ready}, 0);
                repeat (2) @(negedge clk);
                ref_valid = 1'b0; start = 1'b0; rst_n = 1'b1;
                return;
            end
            guard = 0;
            while (!ref_ready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) check("ref_ready timeout", 0, 1);
            @(negedge clk);
        end
        ref_valid = 1'b0; start = 1'b0;
        if (hold_sad >= 0) begin
            check("hold before sad_en", {18'b0, sad_min}, hold_sad);
            check("no early sad_en", {31'b0, sad_en}, 0);
        end
    endtask

    task automatic wait_result(input string tag, input int base_cnt);
        int guard;
        guard = 0;
        while (!sad_en && guard < 20) begin @(negedge clk); guard++; end
        check({tag, " sad_en"}, {31'b0, sad_en}, 1);
        check({tag, " latency"}, cyc - last_ref_cyc, 2);
        check({tag, " sad_min"}, {18'b0, sad_min}, exp_sad);
        check({tag, " mv_x"}, {28'b0, mvx}, exp_x);
        check({tag, " mv_y"}, {28'b0, mvy}, exp_y);
        check({tag, " busy low"}, {31'b0, busy}, 0);
        @(negedge clk);
        check({tag, " pulse"}, {31'b0, sad_en}, 0);
        check({tag, " hold"}, {18'b0, sad_min}, exp_sad);
        check({tag, " one sad_en"}, sad_en_cnt - base_cnt, 1);
    endtask

    initial begin
        int base, prev;
        #12;
        check("rst sad_en", {31'b0, sad_en}, 0);
        check("rst sad_min", {18'b0, sad_min}, 0);
        check("rst mvx", {28'b0, mvx}, 0);
        check("rst mvy", {28'b0, mvy}, 0);
        check("rst busy", {31'b0, busy}, 0);
        check("rst cur_ready", {31'b0, cur_ready}, 0);
        check("rst ref_ready", {31'b0, ref_ready}, 0);
        @(negedge clk); rst_n = 1'b1;

        setup(1); model(); base = sad_en_cnt;
        run(1'b0, 1'b0, -1, -1); wait_result("patch", base);

        setup(2); model(); base = sad_en_cnt;
        run(1'b0, 1'b0, -1, -1); wait_result("all255", base);

        setup(3); model(); base = sad_en_cnt;
        run(1'b0, 1'b0, -1, -1); wait_result("onepix", base);

        setup(1); model(); base = sad_en_cnt;
        run(1'b1, 1'b0, -1, -1); wait_result("patch gaps", base);

        setup(1); model(); base = sad_en_cnt;
        run(1'b0, 1'b0, 10, -1);
        repeat (10) @(negedge clk);
        check("abort no sad_en", sad_en_cnt - base, 0);
        check("abort idle busy", {31'b0, busy}, 0);
        run(1'b0, 1'b0, -1, -1); wait_result("after abort", base);

        prev = exp_sad;
        setup(2); model(); base = sad_en_cnt;
        run(1'b0, 1'b1, -1, prev); wait_result("poke", base);

        setup(4); model(); base = sad_en_cnt;
        run(1'b0, 1'b0, -1, -1); wait_result("rand0", base);

        setup(4); model(); base = sad_en_cnt;
        run(1'b1, 1'b0, -1, -1); wait_result("rand1 gaps", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
